// File: rtl/fft16_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft16_pkg: shared constants, FSM encodings and lane slicing for the  |
// | 16-point FFT datapath.                          Revision: 1.0        |
// +----------------------------------------------------------------------+
package fft16_pkg;

  localparam int DW    = 16;
  localparam int NPTS  = 16;
  localparam int IDX_W = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  function automatic logic [DW-1:0] lane(input logic [DW*NPTS-1:0] bus, input int i);
    return bus[DW*i +: DW];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft16_output_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft16_output_serializer: captures the wide FFT result after a fixed  |
// | latency and streams the bins over valid/ready.  Revision: 1.0        |
// +----------------------------------------------------------------------+
module fft16_output_serializer #(
  parameter int DW          = fft16_pkg::DW,
  parameter int NPTS        = fft16_pkg::NPTS,
  parameter int LATENCY     = 16,
  parameter int SCALE_SHIFT = 0
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          en,
  input  logic                          frame_start,
  input  logic [DW*NPTS-1:0]            x_bus,
  input  logic [DW*NPTS-1:0]            y_bus,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [DW-1:0]          x_out,
  output logic signed [DW-1:0]          y_out,
  output logic [fft16_pkg::IDX_W-1:0]   out_index,
  output logic                          out_last,
  output logic                          busy,
  output logic                          overrun
);

  import fft16_pkg::*;

  localparam int               CNT_W    = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPTS - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [DW-1:0]    bank_x [NPTS];
  logic [DW-1:0]    bank_y [NPTS];

  logic xfer;
  logic final_xfer;

  assign out_valid  = (state == ST_STREAM);
  assign busy       = (state != ST_IDLE);
  assign out_last   = out_valid && (out_index == LAST_IDX);
  assign xfer       = en && out_valid && out_ready;
  assign final_xfer = xfer && (out_index == LAST_IDX);

  // A start is only accepted from IDLE or on the very last transfer of a frame.
  assign overrun = en && frame_start &&
                   ((state == ST_WAIT) || ((state == ST_STREAM) && !final_xfer));

  assign x_out = $signed(bank_x[out_index]) >>> SCALE_SHIFT;
  assign y_out = $signed(bank_y[out_index]) >>> SCALE_SHIFT;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      out_index <= '0;
      for (int i = 0; i < NPTS; i++) begin
        bank_x[i] <= '0;
        bank_y[i] <= '0;
      end
    end else if (en) begin
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            state <= ST_WAIT;
            cnt   <= CNT_W'(LATENCY - 1);
          end
        end
        ST_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            for (int i = 0; i < NPTS; i++) begin
              bank_x[i] <= lane(x_bus, i);
              bank_y[i] <= lane(y_bus, i);
            end
            out_index <= '0;
            state     <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (final_xfer) begin
            out_index <= '0;
            if (frame_start) begin
              state <= ST_WAIT;
              cnt   <= CNT_W'(LATENCY - 1);
            end else begin
              state <= ST_IDLE;
            end
          end else if (xfer) begin
            out_index <= out_index + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/fft16_output_serializer.md
Name: fft16_output_serializer

Overview:
- Downstream consumer of the 16-point FFT stage.
- Waits a fixed pipeline latency after the FFT inputs are applied, then captures the 256-bit real and imaginary result buses into a 16-entry register bank.
- Streams the 16 bins out one per handshake in natural order (bin 0 first), with optional arithmetic down-scaling.
- Decouples the wide parallel FFT result from a narrow valid/ready sample sink.

Parameters:
- DW, 16, width of one real or imaginary lane.
- NPTS, 16, bins per frame; bus width is DW*NPTS.
- LATENCY, 16, enabled cycles from frame_start to result-valid on the FFT buses; legal range 1..255.
- SCALE_SHIFT, 0, arithmetic right shift applied to every streamed lane; legal range 0..DW-1.

Ports:
- clock  in  1  rising-edge clock, shared with the FFT.
- reset_n  in  1  synchronous active-low reset.
- en  in  1  global enable, same net as the FFT enable; when low, all state freezes.
- frame_start  in  1  single-cycle pulse marking the cycle the FFT inputs were applied.
- x_bus  in  256  real results; lane i = bits [16i+15:16i].
- y_bus  in  256  imaginary results, same packing.
- out_valid  out  1  current bin available.
- out_ready  in  1  sink accepts the current bin.
- x_out  out  16  signed real part of the current bin.
- y_out  out  16  signed imaginary part of the current bin.
- out_index  out  4  bin number of the current bin.
- out_last  out  1  high with out_valid when out_index == NPTS-1.
- busy  out  1  high in WAIT or STREAM.
- overrun  out  1  one-cycle pulse when a frame_start is dropped.

Behaviour:
- Reset (reset_n low at an edge): state IDLE; cnt=0; out_index=0; bank cleared to 0. Outputs out_valid, out_last, busy, overrun, x_out and y_out all 0. Reset mid-frame discards the frame with no residue.
- en=0 freezes state, cnt, out_index, bank and overrun (forced 0). Outputs hold their values. No transfer occurs.
- Transfer happens when en & out_valid & out_ready.
- States are IDLE, WAIT and STREAM; all transitions below require en=1.
- IDLE:
  - frame_start=1 at edge k -> WAIT, cnt=LATENCY-1.
- WAIT:
  - cnt!=0 -> cnt decrements.
  - cnt==0 -> capture all 16 lanes of x_bus and y_bus into the bank, out_index=0, go to STREAM. The capture edge is k+LATENCY.
  - out_valid rises after the capture edge.
- STREAM:
  - out_valid=1.
  - x_out = bank_x[out_index] >>> SCALE_SHIFT (sign-preserving); y_out likewise.
  - A transfer increments out_index.
  - A transfer at out_index==15 -> IDLE, out_index wraps to 0.
- Back-pressure: out_ready low holds out_index and the data indefinitely. No timeout.
- Simultaneous events:
  - frame_start in the same cycle as the final transfer (index 15) is accepted: go directly to WAIT with cnt=LATENCY-1.
  - frame_start in WAIT, or in STREAM other than on the final transfer, is dropped: overrun=1 for that cycle and the state is unaffected.
- busy = (state != IDLE).
- Throughput: a frame needs LATENCY+1 cycles to reach the first bin. After that, 16 cycles minimum at out_ready=1.

Decomposition:
- Shared package fft16_pkg holds:
  - constants DW=16, NPTS=16 and IDX_W=4;
  - the state enum {IDLE, WAIT, STREAM};
  - a lane-slice function lane(bus, i) returning bus[16i+:16].
- The function is reused by the FFT top and the bench.
- No sub-module is needed. The bank plus read mux stays inline in one module of roughly 150-200 lines.

Test Plan:
- Basic stream: LATENCY=4, x_bus lane i = 10*i+1, y_bus lane i = -i, frame_start pulse at cycle 0, out_ready=1.
  -> Capture at edge 4; out_valid high over cycles 5..20; bins stream as (1,0), (11,-1) … (151,-15); out_last only with (151,-15); then busy=0.
- Back-pressure: same frame, out_ready toggling 1,0,0,1,… with en=1.
  -> No bin skipped or repeated; 16 transfers total; x_out and y_out stable while out_ready=0.
- Scaling: SCALE_SHIFT=2, lane 3 x=-7, y=8.
  -> Bin 3 streams x=-2, y=2.
- Overrun and chaining:
  - frame_start at cycle 2 of WAIT -> overrun pulse for one cycle, capture timing unchanged.
  - frame_start in the same cycle as the final transfer -> busy stays 1 and the next capture happens LATENCY cycles later.
- Enable freeze: drop en for 3 cycles in mid-WAIT and for 3 cycles in mid-STREAM at index 6.
  -> Capture delayed exactly 3 cycles; index 6 held during the freeze even with out_ready=1.
- Reset mid-operation: reset_n=0 for one edge at index 9 of STREAM.
  -> All outputs 0, state IDLE; the next frame_start streams from index 0 with correct data.
